// File: rtl/sdmf_reduce_pack.sv
// Frame reducer/packer: drops the low TAM_WIDTH time-index bits and merges PACK input beats per output word.
// Optional sub-space range filter enabled by defining SDMF_REDUCE_SUBSPACE_FILTER_EN.
module sdmf_reduce_pack #(
  parameter int I_DATA_WIDTH = 16,
  parameter int PACK         = 3,
  parameter int FDSTI_WIDTH  = 32,
  parameter int FDSSI_WIDTH  = 2,
  parameter int TAM_WIDTH    = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [FDSSI_WIDTH-1:0]              fdssi_l,
  input  logic [FDSSI_WIDTH-1:0]              fdssi_h,
  input  logic                                i_frame_valid,
  input  logic                                i_fi_valid,
  input  logic [FDSTI_WIDTH-1:0]              i_fdsti,
  input  logic [FDSSI_WIDTH-1:0]              i_fdssi,
  input  logic                                i_tvalid,
  output logic                                i_tready,
  input  logic                                i_tlast,
  input  logic [I_DATA_WIDTH-1:0]             i_tdata,
  output logic                                o_frame_valid,
  output logic                                o_fi_valid,
  output logic [FDSTI_WIDTH-TAM_WIDTH-1:0]    o_fdsti,
  output logic [FDSSI_WIDTH-1:0]              o_fdssi,
  output logic                                o_tvalid,
  input  logic                                o_tready,
  output logic                                o_tlast,
  output logic [PACK*I_DATA_WIDTH-1:0]        o_tdata,
  output logic [PACK-1:0]                     o_tkeep,
  output logic [15:0]                         drop_cnt
);

  localparam int O_DATA_WIDTH = PACK * I_DATA_WIDTH;
  localparam int LW           = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int OT_WIDTH     = FDSTI_WIDTH - TAM_WIDTH;

  typedef enum logic [2:0] {IDLE, HDR, DATA, FLUSH, DROP} state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [O_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [O_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [PACK-1:0]         tkeep_q, tkeep_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [OT_WIDTH-1:0]     fdsti_q, fdsti_d;
  logic [FDSSI_WIDTH-1:0]  fdssi_q, fdssi_d;
  logic [15:0]             drop_q, drop_d;

  logic                    in_range;
  logic                    in_rdy;
  logic                    fi_valid;
  logic                    frame_valid;
  logic [O_DATA_WIDTH-1:0] merged;
  logic [PACK-1:0]         keep_mask;
  logic                    unused_bits;

`ifdef SDMF_REDUCE_SUBSPACE_FILTER_EN
  assign in_range    = (i_fdssi >= fdssi_l) && (i_fdssi <= fdssi_h);
  assign unused_bits = ^i_fdsti[TAM_WIDTH-1:0];
`else
  assign in_range    = 1'b1;
  assign unused_bits = ^{i_fdsti[TAM_WIDTH-1:0], fdssi_l, fdssi_h};
`endif

  // Word being assembled with the current beat dropped into its lane; higher lanes stay zero.
  always_comb begin
    merged    = acc_q;
    keep_mask = '0;
    for (int l = 0; l < PACK; l++) begin
      if (LW'(l) == lane_q) merged[l*I_DATA_WIDTH +: I_DATA_WIDTH] = i_tdata;
      if (LW'(l) <= lane_q) keep_mask[l] = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tvalid_d    = tvalid_q && !o_tready;
    fdsti_d     = fdsti_q;
    fdssi_d     = fdssi_q;
    drop_d      = drop_q;
    in_rdy      = 1'b0;
    fi_valid    = 1'b0;
    frame_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_frame_valid && i_fi_valid) begin
          fdsti_d = i_fdsti[FDSTI_WIDTH-1:TAM_WIDTH];
          fdssi_d = i_fdssi;
          if (in_range) begin
            state_d = HDR;
          end else begin
            state_d = DROP;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end
        end
      end
      HDR: begin
        fi_valid    = 1'b1;
        frame_valid = 1'b1;
        state_d     = DATA;
      end
      DATA: begin
        frame_valid = 1'b1;
        in_rdy      = !tvalid_q || o_tready;
        if (i_tvalid && in_rdy) begin
          if ((lane_q == LW'(PACK-1)) || i_tlast) begin
            tdata_d  = merged;
            tkeep_d  = keep_mask;
            tlast_d  = i_tlast;
            tvalid_d = 1'b1;
            lane_d   = '0;
            acc_d    = '0;
          end else begin
            acc_d  = merged;
            lane_d = lane_q + LW'(1);
          end
          if (i_tlast) state_d = FLUSH;
        end
      end
      FLUSH: begin
        frame_valid = 1'b1;
        if (tvalid_q && o_tready && tlast_q) state_d = IDLE;
      end
      DROP: begin
        in_rdy = 1'b1;
        if (i_tvalid && i_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state always uses <= so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // NOTE: datapath registers are reset too, so a mid-frame reset leaves no stale word or lane behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q   <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      fdsti_q  <= '0;
      fdssi_q  <= '0;
      drop_q   <= '0;
    end else begin
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      fdsti_q  <= fdsti_d;
      fdssi_q  <= fdssi_d;
      drop_q   <= drop_d;
    end
  end

  assign i_tready      = in_rdy;
  assign o_fi_valid    = fi_valid;
  assign o_frame_valid = frame_valid;
  assign o_fdsti       = fdsti_q;
  assign o_fdssi       = fdssi_q;
  assign o_tvalid      = tvalid_q;
  assign o_tlast       = tlast_q;
  assign o_tdata       = tdata_q;
  assign o_tkeep       = tkeep_q;
  assign drop_cnt      = drop_q;

endmodule

// File: doc/sdmf_reduce_pack.md
SDMF_REDUCE_PACK -- requirements
Module: sdmf_reduce_pack

Interface
REQ-001 SHALL have parameter I_DATA_WIDTH, default 16, input beat width.
REQ-002 SHALL have parameter PACK, default 3 (range 2..8), input beats merged per output beat; O_DATA_WIDTH = PACK*I_DATA_WIDTH.
REQ-003 SHALL have parameter FDSTI_WIDTH, default 32, input time-index width.
REQ-004 SHALL have parameter FDSSI_WIDTH, default 2, space-index width.
REQ-005 SHALL have parameter TAM_WIDTH, default 4, time-index bits removed by the reduction.
REQ-006 SHALL have ports: clk in 1, clock; reset in 1, asynchronous, active-high.
REQ-007 SHALL have ports: fdssi_l in FDSSI_WIDTH, lower accepted space index; fdssi_h in FDSSI_WIDTH, upper accepted space index.
REQ-008 SHALL have input-frame ports: i_frame_valid in 1; i_fi_valid in 1, header strobe; i_fdsti in FDSTI_WIDTH; i_fdssi in FDSSI_WIDTH.
REQ-009 SHALL have input-stream ports: i_tvalid in 1; i_tready out 1; i_tlast in 1; i_tdata in I_DATA_WIDTH.
REQ-010 SHALL have output-frame ports: o_frame_valid out 1; o_fi_valid out 1; o_fdsti out FDSTI_WIDTH-TAM_WIDTH; o_fdssi out FDSSI_WIDTH.
REQ-011 SHALL have output-stream ports: o_tvalid out 1; o_tready in 1; o_tlast out 1; o_tdata out O_DATA_WIDTH; o_tkeep out PACK, one bit per filled lane.
REQ-012 SHALL have port drop_cnt out 16, count of discarded frames.

Function
REQ-013 SHALL implement FSM states IDLE, HDR, DATA, FLUSH, DROP.
REQ-014 IDLE: on i_frame_valid&&i_fi_valid, SHALL latch i_fdsti[FDSTI_WIDTH-1:TAM_WIDTH] and i_fdssi; go to HDR if fdssi_l<=i_fdssi<=fdssi_h, else DROP.
REQ-015 HDR (one cycle): o_fi_valid=1 and o_frame_valid=1; o_fdsti and o_fdssi hold the latched values until the next header; next state DATA.
REQ-016 DATA: i_tready = !o_tvalid || o_tready; each accepted beat SHALL be written into lane lane_cnt (lane 0 = LSBs); lane_cnt increments.
REQ-017 A word completes when an accepted beat has lane_cnt==PACK-1 or i_tlast=1: the next cycle o_tvalid=1, o_tdata=merged lanes, o_tkeep=filled lanes, o_tlast=i_tlast; unfilled lanes zero; lane_cnt returns to 0.
REQ-018 o_tdata, o_tkeep and o_tlast SHALL stay stable while o_tvalid&&!o_tready; o_tvalid clears after the handshake unless a new word completes in the same cycle.
REQ-019 After the i_tlast handshake SHALL go to FLUSH with i_tready=0; on the o_tlast handshake, o_frame_valid deasserts the following cycle and FSM returns to IDLE.
REQ-020 DROP: i_tready=1, no output activity; on the i_tlast handshake SHALL return to IDLE; drop_cnt increments once per dropped frame, saturating at 0xFFFF.
REQ-021 i_fi_valid outside IDLE SHALL be ignored; i_tready=0 in IDLE and HDR.
REQ-022 Latency: header out 1 cycle after i_fi_valid; data word out 1 cycle after completing input beat.

Reset
REQ-023 On reset, SHALL force: FSM=IDLE, lane_cnt=0, all output valids/o_tlast/o_tkeep/o_tdata/o_fdsti/o_fdssi=0, i_tready=0, drop_cnt=0.
REQ-024 Reset mid-frame SHALL discard partial accumulators and pending output words; the first frame after reset is handled as a fresh frame.

Configuration
REQ-025 Macro SDMF_REDUCE_SUBSPACE_FILTER_EN defined: range filter per REQ-014 and DROP state active.
REQ-026 Macro SDMF_REDUCE_SUBSPACE_FILTER_EN undefined: every frame goes to HDR, fdssi_l/fdssi_h ignored, DROP unreachable, drop_cnt constant 0.

Verification (PACK=3, I_DATA_WIDTH=16, filter enabled, fdssi_l=1, fdssi_h=3)
REQ-027 Frame, i_fdsti=0x12345678, i_fdssi=2 -> o_fi_valid one cycle, o_fdsti=0x1234567, o_fdssi=2.
REQ-028 6 beats 0x0001..0x0006, o_tready=1 -> 2 words 0x000300020001, 0x000600050004, o_tkeep=3'b111, o_tlast on second.
REQ-029 7 beats -> 3 words; third o_tdata=0x000000000007, o_tkeep=3'b001, o_tlast=1.
REQ-030 i_fdssi=0, 4 beats -> i_tready=1 throughout, no o_fi_valid/o_tvalid, drop_cnt=1.
REQ-031 o_tready=0 for 5 cycles mid-frame -> i_tready=0 once a word is pending, output word held stable, no beat lost or duplicated.
REQ-032 reset asserted after beat 2 of a frame -> all outputs 0 next edge; the next frame with 3 beats yields exactly one word with o_tkeep=3'b111.
